addsub_acc_pipe: RTL and testbench

//  Parametrised, pipelined add / reverse-subtract / accumulate unit with valid/ready handshake.

---
 rtl/addsub_acc_if.sv | 27 ++
 rtl/addsub_acc_pipe.sv | 128 ++++++++++++
 tb/tb_addsub_acc_pipe.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/addsub_acc_if.sv
// Handshake and data bundle for addsub_acc_pipe.
// The master drives operands and out_ready. The slave (the unit) drives in_ready and the results.
interface addsub_acc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic [WIDTH-1:0] acc_out;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, acc_out
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, acc_out
    );
endinterface

// File: rtl/addsub_acc_pipe.sv
// Two-stage add / reverse-subtract / accumulate unit with valid/ready flow control.
// Stage 1 captures the request. Stage 2 computes the result, registers it and updates the accumulator.
module addsub_acc_pipe #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0,
    parameter int SIGNED   = 0
) (
    input  logic        clk,
    input  logic        rst,
    addsub_acc_if.slave bus
);
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_RSUB = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;
    logic [WIDTH-1:0] acc_q;

    logic             s2_adv;
    logic             in_ready_c;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             cin;
    logic [WIDTH:0]   raw;
    logic             raw_c;
    logic             raw_v;
    logic [WIDTH-1:0] sat_res;

    assign s2_adv     = !out_valid_q || bus.out_ready;
    assign in_ready_c = !s1_valid || s2_adv;

    // LOAD is computed as a + 0. Its carry and overflow therefore fall out as 0 without any special case.
    always_comb begin
        op_x = s1_a;
        op_y = s1_b;
        cin  = 1'b0;
        case (s1_op)
            OP_ADD: begin
                op_x = s1_a;
                op_y = s1_b;
            end
            OP_RSUB: begin
                op_x = ~s1_a;
                op_y = s1_b;
                cin  = 1'b1;
            end
            OP_ACC: begin
                op_x = acc_q;
                op_y = s1_a;
            end
            default: begin
                op_x = s1_a;
                op_y = '0;
            end
        endcase

        raw     = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, cin};
        raw_c   = raw[WIDTH];
        raw_v   = (op_x[WIDTH-1] == op_y[WIDTH-1]) && (raw[WIDTH-1] != op_x[WIDTH-1]);
        sat_res = raw[WIDTH-1:0];

        if (SATURATE != 0) begin
            if (SIGNED != 0) begin
                if (raw_v)
                    sat_res = op_x[WIDTH-1] ? MIN_NEG : MAX_POS;
            end else if (s1_op == OP_RSUB) begin
                if (!raw_c)
                    sat_res = '0;
            end else if (raw_c) begin
                sat_res = ALL_ONES;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_op       <= OP_ADD;
            s1_a        <= '0;
            s1_b        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            acc_q       <= '0;
        end else begin
            if (in_ready_c) begin
                s1_valid <= bus.in_valid;
                // Operands are sampled only with a real transfer, so idle-bus garbage never enters the pipe.
                if (bus.in_valid) begin
                    s1_op <= bus.op;
                    s1_a  <= bus.a;
                    s1_b  <= bus.b;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    result_q   <= sat_res;
                    carry_q    <= raw_c;
                    overflow_q <= raw_v;
                    if (s1_op[1])
                        acc_q <= sat_res;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.acc_out   = acc_q;
endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Directed bench for addsub_acc_pipe. It drives three instances in parallel with identical stimulus:
// one that wraps, one with unsigned saturation and one with signed saturation.
module tb_addsub_acc_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int snap;

    addsub_acc_if #(.WIDTH(8)) bus0 ();
    addsub_acc_if #(.WIDTH(8)) bus1 ();
    addsub_acc_if #(.WIDTH(8)) bus2 ();

    assign bus0.in_valid = in_valid;
    assign bus0.op = op;
    assign bus0.a = a;
    assign bus0.b = b;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid = in_valid;
    assign bus1.op = op;
    assign bus1.a = a;
    assign bus1.b = b;
    assign bus1.out_ready = out_ready;
    assign bus2.in_valid = in_valid;
    assign bus2.op = op;
    assign bus2.a = a;
    assign bus2.b = b;
    assign bus2.out_ready = out_ready;

    addsub_acc_pipe #(.WIDTH(8), .SATURATE(0), .SIGNED(0)) dut_wrap (.clk(clk), .rst(rst), .bus(bus0));
    addsub_acc_pipe #(.WIDTH(8), .SATURATE(1), .SIGNED(0)) dut_usat (.clk(clk), .rst(rst), .bus(bus1));
    addsub_acc_pipe #(.WIDTH(8), .SATURATE(1), .SIGNED(1)) dut_ssat (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && bus0.out_valid && out_ready)
            n_out <= n_out + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        in_valid = v;
        op = o;
        a = x;
        b = y;
    endtask

    task automatic check_out(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                             input logic [7:0] r2, input logic c, input logic v);
        check({tag, "_vld"}, 32'(bus0.out_valid), 32'(1));
        check({tag, "_r_wrap"}, 32'(bus0.result), 32'(r0));
        check({tag, "_r_usat"}, 32'(bus1.result), 32'(r1));
        check({tag, "_r_ssat"}, 32'(bus2.result), 32'(r2));
        check({tag, "_c"}, 32'(bus0.carry), 32'(c));
        check({tag, "_c_usat"}, 32'(bus1.carry), 32'(c));
        check({tag, "_v"}, 32'(bus0.overflow), 32'(v));
        check({tag, "_v_ssat"}, 32'(bus2.overflow), 32'(v));
    endtask

    task automatic check_acc(input string tag, input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
        check({tag, "_acc_wrap"}, 32'(bus0.acc_out), 32'(a0));
        check({tag, "_acc_usat"}, 32'(bus1.acc_out), 32'(a1));
        check({tag, "_acc_ssat"}, 32'(bus2.acc_out), 32'(a2));
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 2'b10, 8'hA5, 8'h5A);
        step();
        check("rst_ovld", 32'(bus0.out_valid), 32'(0));
        check("rst_res", 32'(bus0.result), 32'(0));
        check("rst_flags", 32'({bus0.carry, bus0.overflow}), 32'(0));
        check("rst_rdy", 32'(bus0.in_ready), 32'(1));
        check_acc("rst", 8'h00, 8'h00, 8'h00);
        rst = 1'b0;

        // Garbage on an idle bus must not reach outputs or the accumulator.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            step();
        end
        check("idle_ovld", 32'(bus0.out_valid), 32'(0));
        check_acc("idle", 8'h00, 8'h00, 8'h00);

        drive(1'b1, 2'b00, 8'h10, 8'h20);
        step();
        check("t1_lat1", 32'(bus0.out_valid), 32'(0));
        drive(1'b1, 2'b00, 8'hFF, 8'h01);
        step();
        check_out("t1_add", 8'h30, 8'h30, 8'h30, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check_out("t1_addc", 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
        check_acc("t1", 8'h00, 8'h00, 8'h00);
        step();
        check("t1_drain", 32'(bus0.out_valid), 32'(0));

        drive(1'b1, 2'b01, 8'h05, 8'h03);
        step();
        drive(1'b1, 2'b01, 8'h03, 8'h05);
        step();
        check_out("t2_rsub_neg", 8'hFE, 8'h00, 8'hFE, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check_out("t2_rsub_pos", 8'h02, 8'h02, 8'h02, 1'b1, 1'b0);
        step();

        drive(1'b1, 2'b11, 8'h7F, 8'h00);
        step();
        drive(1'b1, 2'b10, 8'h01, 8'hEE);
        step();
        check_out("t3_load", 8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0);
        check_acc("t3_load", 8'h7F, 8'h7F, 8'h7F);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check_out("t3_acc", 8'h80, 8'h80, 8'h7F, 1'b0, 1'b1);
        check_acc("t3_acc", 8'h80, 8'h80, 8'h7F);
        step();

        drive(1'b1, 2'b11, 8'h00, 8'h00);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b10, 8'h01, 8'h00);
            step();
            check($sformatf("t4_res%0d", i), 32'(bus0.result), 32'(i));
            check($sformatf("t4_vld%0d", i), 32'(bus0.out_valid), 32'(1));
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("t4_res4", 32'(bus0.result), 32'(4));
        check_acc("t4", 8'h04, 8'h04, 8'h04);
        step();
        check("t4_drain", 32'(bus0.out_valid), 32'(0));

        snap = n_out;
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 8'h01, 8'h02);
        step();
        check("t5_rdy1", 32'(bus0.in_ready), 32'(1));
        drive(1'b1, 2'b00, 8'h03, 8'h04);
        step();
        check("t5_full", 32'(bus0.in_ready), 32'(0));
        check("t5_hold0", 32'(bus0.result), 32'(3));
        drive(1'b1, 2'b00, 8'h05, 8'h06);
        for (int i = 1; i < 3; i++) begin
            step();
            check($sformatf("t5_stall_rdy%0d", i), 32'(bus0.in_ready), 32'(0));
            check($sformatf("t5_hold%0d", i), 32'(bus0.result), 32'(3));
        end
        out_ready = 1'b1;
        step();
        check("t5_out2", 32'(bus0.result), 32'(7));
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("t5_out3", 32'(bus0.result), 32'(11));
        check("t5_out3_vld", 32'(bus0.out_valid), 32'(1));
        step();
        check("t5_drain", 32'(bus0.out_valid), 32'(0));
        check("t5_count", 32'(n_out - snap), 32'(3));
        check_acc("t5", 8'h04, 8'h04, 8'h04);

        snap = n_out;
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 8'h02, 8'h00);
        step();
        drive(1'b1, 2'b10, 8'h03, 8'h00);
        step();
        check("t6_full", 32'(bus0.in_ready), 32'(0));
        check_acc("t6_pre", 8'h06, 8'h06, 8'h06);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_ovld", 32'(bus0.out_valid), 32'(0));
        check("t6_rst_res", 32'(bus0.result), 32'(0));
        check("t6_rst_rdy", 32'(bus0.in_ready), 32'(1));
        check_acc("t6_rst", 8'h00, 8'h00, 8'h00);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 8'h21, 8'h12);
        step();
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check_out("t6_post", 8'h33, 8'h33, 8'h33, 1'b0, 1'b0);
        check_acc("t6_post", 8'h00, 8'h00, 8'h00);
        check("t6_no_hs", 32'(n_out - snap), 32'(0));
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
